// File: rtl/mult_accum_ctrl_if.sv
// Operand/result handshake bundle for mult_accum_ctrl, including the multiplier-facing signals.
// slave is the controller's view; master is the environment (source, sink and multiplier).
interface mult_accum_ctrl_if #(
    parameter int ACC_W = 24
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic [15:0]      mul_p;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, mul_p, out_ready,
        output in_ready, mul_a, mul_b, out_valid, out_sum, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/mult_accum_ctrl.sv
// Issues operand pairs to a pipelined 8x8 multiplier, waits out its latency and accumulates
// N_TERMS products into one dot-product result handed downstream over valid/ready.
module mult_accum_ctrl #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 24,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_accum_ctrl_if.slave      bus,
    output logic                  busy
);
    localparam int TCW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int LCW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mul_a_q, mul_a_d;
    logic [7:0]       mul_b_q, mul_b_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [TCW-1:0]   term_cnt_q, term_cnt_d;
    logic [LCW-1:0]   lat_cnt_q, lat_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_ovf_q, out_ovf_d;
    logic [ACC_W:0]   acc_sum;

    // One extra bit so the carry out of the wrapped accumulator feeds the sticky overflow flag.
    assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(bus.mul_p);

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        acc_d       = acc_q;
        term_cnt_d  = term_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        out_valid_d = out_valid_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mul_a_d   = bus.in_a;
                    mul_b_d   = bus.in_b;
                    lat_cnt_d = LCW'(MUL_LAT);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end else begin
                    acc_d      = acc_sum[ACC_W-1:0];
                    out_ovf_d  = out_ovf_q | acc_sum[ACC_W];
                    term_cnt_d = term_cnt_q + 1'b1;
                    if (term_cnt_q == TCW'(N_TERMS - 1)) begin
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_d       = '0;
                    term_cnt_d  = '0;
                    out_ovf_d   = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            acc_q       <= '0;
            term_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values regardless of order.
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            acc_q       <= acc_d;
            term_cnt_q  <= term_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // in_ready is a pure state decode, so it never depends on in_valid.
    assign bus.in_ready  = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mult_accum_ctrl.sv
// Four builds of mult_accum_ctrl share one stimulus stream; each has its own multiplier model
// and a frame-level reference (sum of accepted products, modular wrap, overflow if total >= 2^ACC_W).
`timescale 1ns/1ps
module tb_mult_accum_ctrl;
    localparam int ND = 4;

    function automatic int nt_of(input int k);
        return (k == 2) ? 4 : 8;
    endfunction
    function automatic int aw_of(input int k);
        return (k == 1) ? 16 : 24;
    endfunction
    function automatic int lt_of(input int k);
        return (k == 3) ? 3 : 1;
    endfunction

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       busy0, busy1, busy2, busy3;
    logic [15:0] p0 = '0, p1 = '0, p2 = '0, p3a = '0, p3b = '0, p3c = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cont_mode = 1'b0;

    always #5 clk = ~clk;

    mult_accum_ctrl_if #(.ACC_W(24)) i0 ();
    mult_accum_ctrl_if #(.ACC_W(16)) i1 ();
    mult_accum_ctrl_if #(.ACC_W(24)) i2 ();
    mult_accum_ctrl_if #(.ACC_W(24)) i3 ();

    mult_accum_ctrl #(.N_TERMS(8), .ACC_W(24), .MUL_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(i0.slave), .busy(busy0));
    mult_accum_ctrl #(.N_TERMS(8), .ACC_W(16), .MUL_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave), .busy(busy1));
    mult_accum_ctrl #(.N_TERMS(4), .ACC_W(24), .MUL_LAT(1)) u2 (.clk(clk), .rst(rst), .bus(i2.slave), .busy(busy2));
    mult_accum_ctrl #(.N_TERMS(8), .ACC_W(24), .MUL_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(i3.slave), .busy(busy3));

    assign i0.in_valid = in_valid;  assign i0.in_a = in_a;  assign i0.in_b = in_b;
    assign i0.out_ready = out_ready; assign i0.mul_p = p0;
    assign i1.in_valid = in_valid;  assign i1.in_a = in_a;  assign i1.in_b = in_b;
    assign i1.out_ready = out_ready; assign i1.mul_p = p1;
    assign i2.in_valid = in_valid;  assign i2.in_a = in_a;  assign i2.in_b = in_b;
    assign i2.out_ready = out_ready; assign i2.mul_p = p2;
    assign i3.in_valid = in_valid;  assign i3.in_a = in_a;  assign i3.in_b = in_b;
    assign i3.out_ready = out_ready; assign i3.mul_p = p3c;

    // Pipelined multiplier models: product appears MUL_LAT edges after the operands.
    always @(posedge clk) begin
        p0  <= 16'(i0.mul_a) * 16'(i0.mul_b);
        p1  <= 16'(i1.mul_a) * 16'(i1.mul_b);
        p2  <= 16'(i2.mul_a) * 16'(i2.mul_b);
        p3a <= 16'(i3.mul_a) * 16'(i3.mul_b);
        p3b <= p3a;
        p3c <= p3b;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state per build
    res_t        exp_q[ND][$];
    longint      run_sum[ND];
    int          run_cnt[ND], frames_exp[ND], outs[ND], hs_cnt[ND];
    int          first_hs_cyc[ND], first_ov_cyc[ND], first_ov_len[ND], last_hs_cyc[ND];
    logic [31:0] first_sum[ND], last_sum[ND];
    logic        first_ovf[ND], prev_hs[ND];
    logic [7:0]  prev_a[ND], prev_b[ND], prev_ma[ND], prev_mb[ND];

    task automatic mon(input int k, input logic r, input logic hs_in, input logic [7:0] a,
                       input logic [7:0] b, input logic ov, input logic ordy,
                       input logic [31:0] sum, input logic ovf, input logic [7:0] ma,
                       input logic [7:0] mb);
        res_t   e;
        longint m;
        if (r) begin
            chk($sformatf("d%0d_rst_mul_a", k), ma, 0);
            chk($sformatf("d%0d_rst_out_valid", k), ov, 0);
            exp_q[k].delete();
            run_sum[k] = 0; run_cnt[k] = 0; frames_exp[k] = 0; outs[k] = 0; hs_cnt[k] = 0;
            first_hs_cyc[k] = -1; first_ov_cyc[k] = -1; first_ov_len[k] = 0;
            prev_hs[k] = 1'b0; prev_ma[k] = 8'd0; prev_mb[k] = 8'd0;
            return;
        end
        if (prev_hs[k]) begin
            chk($sformatf("d%0d_mul_a_load", k), ma, prev_a[k]);
            chk($sformatf("d%0d_mul_b_load", k), mb, prev_b[k]);
        end else begin
            chk($sformatf("d%0d_mul_a_hold", k), ma, prev_ma[k]);
            chk($sformatf("d%0d_mul_b_hold", k), mb, prev_mb[k]);
        end
        if (ov) begin
            if (first_ov_cyc[k] < 0) first_ov_cyc[k] = cyc;
            if (outs[k] == 0) first_ov_len[k]++;
            if (exp_q[k].size() > 0) begin
                chk($sformatf("d%0d_out_sum", k), sum, exp_q[k][0].sum);
                chk($sformatf("d%0d_out_ovf", k), ovf, exp_q[k][0].ovf);
            end
            if (ordy) begin
                if (outs[k] == 0) begin
                    first_sum[k] = sum;
                    first_ovf[k] = ovf;
                end
                outs[k]++;
                last_sum[k] = sum;
                if (exp_q[k].size() > 0) void'(exp_q[k].pop_front());
            end
        end
        if (hs_in) begin
            if (cont_mode && run_cnt[k] > 0)
                chk($sformatf("d%0d_issue_gap", k), cyc - last_hs_cyc[k], lt_of(k) + 2);
            if (first_hs_cyc[k] < 0) first_hs_cyc[k] = cyc;
            last_hs_cyc[k] = cyc;
            hs_cnt[k]++;
            run_sum[k] += longint'(a) * longint'(b);
            run_cnt[k]++;
            if (run_cnt[k] == nt_of(k)) begin
                m = longint'(1) << aw_of(k);
                e.sum = 32'(run_sum[k] % m);
                e.ovf = (run_sum[k] >= m);
                exp_q[k].push_back(e);
                frames_exp[k]++;
                run_sum[k] = 0;
                run_cnt[k] = 0;
            end
        end
        prev_hs[k] = hs_in; prev_a[k] = a; prev_b[k] = b; prev_ma[k] = ma; prev_mb[k] = mb;
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, rst, i0.in_valid && i0.in_ready, i0.in_a, i0.in_b, i0.out_valid, i0.out_ready,
            32'(i0.out_sum), i0.out_ovf, i0.mul_a, i0.mul_b);
        mon(1, rst, i1.in_valid && i1.in_ready, i1.in_a, i1.in_b, i1.out_valid, i1.out_ready,
            32'(i1.out_sum), i1.out_ovf, i1.mul_a, i1.mul_b);
        mon(2, rst, i2.in_valid && i2.in_ready, i2.in_a, i2.in_b, i2.out_valid, i2.out_ready,
            32'(i2.out_sum), i2.out_ovf, i2.mul_a, i2.mul_b);
        mon(3, rst, i3.in_valid && i3.in_ready, i3.in_a, i3.in_b, i3.out_valid, i3.out_ready,
            32'(i3.out_sum), i3.out_ovf, i3.mul_a, i3.mul_b);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cont_mode = 1'b0;
        in_valid  = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", i0.in_ready, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_out_valid", i0.out_valid, 0);
        chk("rst_out_sum", i0.out_sum, 0);
        chk("rst_out_ovf", i0.out_ovf, 0);
        chk("rst_mul_b", i0.mul_b, 0);
    endtask

    task automatic wait_outs(input int k, input int n, input int budget);
        int t = 0;
        while (outs[k] < n && t < budget) begin
            step();
            t++;
        end
        if (outs[k] < n) chk($sformatf("d%0d_wait_result_timeout", k), outs[k], n);
    endtask

    task automatic end_scenario();
        cont_mode = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();
        for (int k = 0; k < ND; k++)
            chk($sformatf("d%0d_frame_count", k), outs[k], frames_exp[k]);
    endtask

    logic [7:0] sp_a [4];
    logic [7:0] sp_b [4];

    initial begin
        int t;
        sp_a[0] = 8'd10; sp_a[1] = 8'd7; sp_a[2] = 8'd0;   sp_a[3] = 8'd255;
        sp_b[0] = 8'd20; sp_b[1] = 8'd9; sp_b[2] = 8'd200; sp_b[3] = 8'd1;

        // Held-valid 3x5 frames: issue spacing, latency, single-cycle result pulse
        do_reset();
        out_ready = 1'b1; in_a = 8'd3; in_b = 8'd5; cont_mode = 1'b1; in_valid = 1'b1;
        wait_outs(0, 1, 200);
        chk("s1_busy_after_handoff", busy0, 0);
        chk("s1_in_ready_after_handoff", i0.in_ready, 1);
        for (int k = 1; k < ND; k++) wait_outs(k, 1, 200);
        chk("s1_d0_sum", first_sum[0], 120);
        chk("s1_d0_ovf", first_ovf[0], 0);
        chk("s1_lat3_sum", first_sum[3], 120);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("s1_d%0d_latency", k), first_ov_cyc[k] - first_hs_cyc[k],
                nt_of(k) * (lt_of(k) + 2));
            chk($sformatf("s1_d%0d_pulse_len", k), first_ov_len[k], 1);
        end
        end_scenario();

        // 255x255 frames: no wrap at 24 bits, wrap and overflow at 16 bits
        do_reset();
        out_ready = 1'b1; in_a = 8'd255; in_b = 8'd255; cont_mode = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < ND; k++) wait_outs(k, 1, 200);
        chk("s2_d0_sum", first_sum[0], 520200);
        chk("s2_d0_ovf", first_ovf[0], 0);
        chk("s2_d16_sum", first_sum[1], 61448);
        chk("s2_d16_ovf", first_ovf[1], 1);
        end_scenario();

        // Result back-pressure for 5 cycles, then a 1x1 frame proves the accumulator cleared
        do_reset();
        out_ready = 1'b0; in_a = 8'd9; in_b = 8'd7; cont_mode = 1'b1; in_valid = 1'b1;
        t = 0;
        while (i0.out_valid !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        chk("s3_out_valid_rise", i0.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("s3_stall_valid", i0.out_valid, 1);
            chk("s3_stall_sum", i0.out_sum, 504);
            chk("s3_stall_ovf", i0.out_ovf, 0);
            chk("s3_stall_in_ready", i0.in_ready, 0);
            step();
        end
        out_ready = 1'b1; in_a = 8'd1; in_b = 8'd1;
        step();
        chk("s3_handoff_valid_low", i0.out_valid, 0);
        chk("s3_handoff_in_ready", i0.in_ready, 1);
        wait_outs(0, 2, 200);
        chk("s3_next_frame_sum", last_sum[0], 8);
        end_scenario();

        // Sparse valid into the 4-term build
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = sp_a[i]; in_b = sp_b[i]; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            repeat (4) step();
        end
        wait_outs(2, 1, 50);
        chk("s4_n4_sum", first_sum[2], 518);
        chk("s4_n4_ovf", first_ovf[2], 0);
        chk("s4_n4_handshakes", hs_cnt[2], 4);
        end_scenario();

        // Asynchronous reset during the fifth term's wait
        do_reset();
        out_ready = 1'b1; in_a = 8'd7; in_b = 8'd7; cont_mode = 1'b1; in_valid = 1'b1;
        t = 0;
        while (hs_cnt[0] < 5 && t < 100) begin
            step();
            t++;
        end
        chk("s5_reached_term5", hs_cnt[0], 5);
        chk("s5_busy_in_wait", busy0, 1);
        chk("s5_partial_acc", i0.out_sum, 196);
        #1 rst = 1'b1;
        #1;
        chk("s5_async_busy", busy0, 0);
        chk("s5_async_out_valid", i0.out_valid, 0);
        chk("s5_async_acc", i0.out_sum, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_a = 8'd2; in_b = 8'd2;
        wait_outs(0, 1, 200);
        chk("s5_fresh_sum", first_sum[0], 32);
        end_scenario();

        // Randomized traffic against the frame-level reference
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                in_a = 8'd255;
                in_b = 8'd255;
            end else begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end
            step();
        end
        end_scenario();
        for (int k = 0; k < ND; k++)
            chk($sformatf("rand_d%0d_produced_frames", k), outs[k] > 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mult_accum_ctrl.md
Name: mult_accum_ctrl

Overview:
- Operand-issue and accumulate controller wrapped around the team's pipelined 8x8 multiplier.
- Accepts an (a, b) operand stream over a valid/ready handshake and drives the multiplier with register-stable operands.
- Samples the 16-bit product after the multiplier's pipeline latency and accumulates N_TERMS products.
- Presents the dot-product sum downstream over a second valid/ready handshake.

Parameters:
- N_TERMS, 8, products summed per frame (>=1).
- ACC_W, 24, accumulator/result width (>=16).
- MUL_LAT, 1, register stages inside the multiplier between operands and full product.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_a  in  8  operand a
- in_b  in  8  operand b
- mul_a  out  8  to multiplier a; registered copy of accepted in_a
- mul_b  out  8  to multiplier b; registered copy of accepted in_b
- mul_p  in  16  product from multiplier
- out_valid  out  1  frame result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  ACC_W  accumulated sum
- out_ovf  out  1  sticky overflow flag for this frame
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: one clock, asynchronous active-high reset. On reset:
  - state=IDLE; op regs (mul_a, mul_b)=0; acc=0; term_cnt=0; lat_cnt=0.
  - out_valid=0, out_ovf=0, out_sum=0, busy=0, in_ready=1 (first cycle after release).
  - Reset mid-frame discards partial sums; no result is emitted.
- States: IDLE, WAIT, DONE. in_ready = (state==IDLE), decoded from the state register only.
- IDLE: on in_valid&&in_ready at edge E0:
  - mul_a<=in_a, mul_b<=in_b, lat_cnt<=MUL_LAT, go WAIT.
  - in_valid without handshake: no effect.
- WAIT:
  - mul_a/mul_b held stable throughout, so the combinational and registered parts of the multiplier product agree.
  - lat_cnt decrements each edge while nonzero.
  - At the edge where lat_cnt==0 (edge E0+MUL_LAT+1): acc<=acc+zero-extended mul_p; term_cnt<=term_cnt+1.
  - Go DONE if term_cnt==N_TERMS-1, else IDLE.
- Throughput and latency:
  - One term per MUL_LAT+2 cycles (3 at default). Next handshake earliest at E0+MUL_LAT+2.
  - Result latency: out_valid rises the cycle after the final accumulate edge.
- Arithmetic:
  - Sum computed at ACC_W+1 bits; acc takes the low ACC_W bits (wrap modulo 2^ACC_W).
  - If bit ACC_W of the sum is 1, out_ovf<=1. Sticky until frame handoff.
- DONE:
  - out_valid=1; out_sum=acc and out_ovf held stable until out_valid&&out_ready.
  - On handoff edge: acc<=0, term_cnt<=0, out_ovf<=0, out_valid<=0, go IDLE.
  - out_ready low: remain in DONE indefinitely; in_ready=0, so inputs are back-pressured.
- out_sum is driven from acc in all states; it is only meaningful when out_valid=1.
- mul_p is ignored outside the accumulate edge.
- Handshake rules:
  - in_ready does not depend combinationally on in_valid.
  - out_valid does not depend on out_ready; once asserted it stays high until accepted.
- N_TERMS=1: every accepted pair produces a result frame.

Test Plan:
- Reset, then 8 pairs a=3, b=5, in_valid held high, out_ready=1 -> handshakes every 3 cycles; single out_valid pulse with out_sum=120, out_ovf=0; busy low after handoff.
- 8 pairs a=255, b=255, ACC_W=24 -> out_sum=520200, out_ovf=0. Same frame with ACC_W=16 -> out_sum=61448, out_ovf=1.
- Completed frame with out_ready held low 5 cycles:
  - out_valid, out_sum, out_ovf stable for all 5 cycles; in_ready=0 while in_valid=1.
  - After out_ready=1: one-cycle handoff, then in_ready=1.
  - Next frame of eight 1x1 pairs -> out_sum=8 (confirms acc cleared).
- Sparse in_valid (1 cycle on, 4 off) over a 4-term frame of 10x20, 7x9, 0x200, 255x1 (N_TERMS=4) -> out_sum=518. mul_a/mul_b change only at handshake edges.
- Assert rst asynchronously (mid-cycle) during WAIT of term 5 -> busy, out_valid, acc drop immediately without a clock edge. Fresh 8-term frame of 2x2 -> out_sum=32.
- MUL_LAT=3 build -> handshakes spaced 5 cycles; out_sum identical to the default build for the first scenario.
